cnt_ctrl: RTL and testbench
===========================

CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port timer_en, input, 1 bit: 1 = counting permitted.
REQ-004 SHALL have port div_en, input, 1 bit: 1 = prescaler active.
REQ-005 SHALL have port div_val, input, 4 bits: prescale exponent; tick period = 2^div_val cycles; values 9..15 SHALL behave as 8.
REQ-006 SHALL have port halt_req, input, 1 bit: debug halt request.
REQ-007 SHALL have port halt_ack, output, 1 bit: 1 = counter frozen by halt.
REQ-008 SHALL have port tdr0_wr_sel, input, 1 bit: write strobe for cnt[31:0].
REQ-009 SHALL have port tdr1_wr_sel, input, 1 bit: write strobe for cnt[63:32].
REQ-010 SHALL have port wdata, input, 32 bits: write data.
REQ-011 SHALL have port pstrb, input, 4 bits: byte enables for wdata.
REQ-012 SHALL have port cnt, output, 64 bits: counter value, registered.
REQ-013 SHALL have port cnt_tick, output, 1 bit: registered one-cycle pulse, 1 in the cycle after each increment.

Function
REQ-014 SHALL implement states IDLE, RUN, HALTED in a registered FSM.
REQ-015 IDLE->RUN SHALL occur when timer_en=1 and halt_req=0; RUN->IDLE when timer_en=0.
REQ-016 IDLE or RUN ->HALTED SHALL occur when halt_req=1; halt_req SHALL take priority over timer_en.
REQ-017 HALTED->RUN SHALL occur when halt_req=0 and timer_en=1; HALTED->IDLE when halt_req=0 and timer_en=0.
REQ-018 halt_ack SHALL be 1 exactly while the FSM is HALTED: it rises one cycle after halt_req is sampled 1 and falls one cycle after halt_req is sampled 0.
REQ-019 An 8-bit prescale counter SHALL increment each cycle in RUN; terminal is count = 2^div_val-1, at which it wraps to 0.
REQ-020 With div_en=0 or div_val=0, terminal SHALL be true every cycle.
REQ-021 The prescale counter SHALL clear in IDLE, when div_en=0, and in the cycle after any change of div_val or div_en; it SHALL hold its value in HALTED.
REQ-022 cnt SHALL increment by 1 on each edge where state=RUN and terminal=1; 64'hFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 with no flag.
REQ-023 A write SHALL update only the bytes of the selected word whose pstrb bit is 1; all other bytes hold.
REQ-024 A write in a cycle that would increment SHALL take priority: that cycle SHALL apply no increment, and cnt_tick SHALL stay 0.
REQ-025 Writes SHALL be accepted in every state; tdr0_wr_sel and tdr1_wr_sel both 1 SHALL update both words.
REQ-026 cnt_tick SHALL never be 1 in IDLE or HALTED.

Reset
REQ-027 sys_rst=1 SHALL, at the next edge: state=IDLE, cnt=0, prescale counter=0, halt_ack=0, cnt_tick=0.
REQ-028 Reset mid-count or mid-halt SHALL override all other inputs, including writes.

Configuration
REQ-029 With macro CNT_HALT_EN defined, halt behaviour SHALL be per REQ-016..018.
REQ-030 Without CNT_HALT_EN: the HALTED state SHALL be absent, halt_req SHALL be ignored, halt_ack SHALL be constant 0, and the port list SHALL be unchanged.

Verification
REQ-031 Reset, then timer_en=1, div_en=0 for 10 cycles -> cnt=9 (first increment one cycle after entering RUN), cnt_tick high on each of those increments.
REQ-032 div_en=1, div_val=2, RUN for 16 cycles -> cnt advances by 4, cnt_tick pulses every 4th cycle; div_val=12 -> period 256.
REQ-033 tdr0/tdr1 write cnt=64'hFFFF_FFFF_FFFF_FFFE, run div 0 -> FFFE, FFFF, 0, 1; no flag on wrap.
REQ-034 RUN at cnt=5, halt_req=1 for 6 cycles -> halt_ack high next cycle, cnt frozen, prescale value retained; on release counting resumes with no lost or extra tick.
REQ-035 tdr0_wr_sel=1, pstrb=4'b0010, wdata=32'h0000_AB00 in an increment cycle with cnt=32'h10 low word -> low word=32'h0000_AB10, no increment that cycle.
REQ-036 CNT_HALT_EN undefined: halt_req=1 during RUN -> counting continues, halt_ack stays 0.

Source files
------------

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: 64-bit free-running timer with power-of-two prescaler,
// byte-maskable word writes and an optional debug-halt state.
// Optional feature macro: CNT_HALT_EN (enables the HALTED state,
// halt_req handling and halt_ack; without it halt_ack is tied to 0).
module cnt_ctrl (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    output logic        halt_ack,
    input  logic        tdr0_wr_sel,
    input  logic        tdr1_wr_sel,
    input  logic [31:0] wdata,
    input  logic [3:0]  pstrb,
    output logic [63:0] cnt,
    output logic        cnt_tick
);

`ifdef CNT_HALT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t      r_state;
    logic [7:0]  r_pre;
    logic [3:0]  r_div_val_q;
    logic        r_div_en_q;
    logic [63:0] r_cnt;
    logic        r_tick;

    logic        w_halt;
    logic [3:0]  w_dv_eff;
    logic [8:0]  w_span;
    logic        w_term;
    logic        w_cfg_chg;
    logic        w_run_edge;
    logic        w_inc;
    logic        w_wr;

    // Replace the bytes of a word selected by the byte strobes
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

`ifdef CNT_HALT_EN
    logic r_halt_ack;
    assign w_halt   = halt_req;
    assign halt_ack = r_halt_ack;
`else
    logic w_unused_halt;
    assign w_unused_halt = halt_req;
    assign w_halt        = 1'b0;
    assign halt_ack      = 1'b0;
`endif

    // Exponents above 8 saturate so the 8-bit prescaler never overflows its span
    assign w_dv_eff  = (div_val > 4'd8) ? 4'd8 : div_val;
    assign w_span    = (9'd1 << w_dv_eff) - 9'd1;
    assign w_term    = !div_en || (w_dv_eff == 4'd0) || (r_pre == w_span[7:0]);
    assign w_cfg_chg = (div_val != r_div_val_q) || (div_en != r_div_en_q);

    // A counting edge is one where the FSM stays in RUN; edges that leave RUN
    // neither advance the prescaler nor the counter, so every increment gets its
    // tick while still in RUN and a halt loses or adds no tick.
    assign w_run_edge = (r_state == RUN) && timer_en && !w_halt;
    assign w_inc      = w_run_edge && w_term;
    assign w_wr       = tdr0_wr_sel || tdr1_wr_sel;

    // Control FSM with registered halt acknowledge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
`ifdef CNT_HALT_EN
            r_halt_ack <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef CNT_HALT_EN
                    if (w_halt) begin
                        r_state    <= HALTED;
                        r_halt_ack <= 1'b1;
                    end else
`endif
                    if (timer_en) r_state <= RUN;
                end
                RUN: begin
`ifdef CNT_HALT_EN
                    if (w_halt) begin
                        r_state    <= HALTED;
                        r_halt_ack <= 1'b1;
                    end else
`endif
                    if (!timer_en) r_state <= IDLE;
                end
`ifdef CNT_HALT_EN
                HALTED: begin
                    if (!halt_req) begin
                        r_halt_ack <= 1'b0;
                        r_state    <= timer_en ? RUN : IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
`ifdef CNT_HALT_EN
                    r_halt_ack <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Remember the prescale configuration so a change can restart the prescaler
    always_ff @(posedge sys_clk) begin
        r_div_val_q <= div_val;
        r_div_en_q  <= div_en;
    end

    // Prescaler: cleared when idle/disabled/reconfigured, held otherwise
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pre <= 8'd0;
        end else if ((r_state == IDLE) || !div_en || w_cfg_chg) begin
            r_pre <= 8'd0;
        end else if (w_run_edge) begin
            r_pre <= w_term ? 8'd0 : r_pre + 8'd1;
        end
    end

    // Counter: writes win over increments; tick marks each real increment
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt  <= 64'd0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_inc && !w_wr;
            if (w_wr) begin
                if (tdr0_wr_sel) r_cnt[31:0]  <= byte_merge(r_cnt[31:0], wdata, pstrb);
                if (tdr1_wr_sel) r_cnt[63:32] <= byte_merge(r_cnt[63:32], wdata, pstrb);
            end else if (w_inc) begin
                r_cnt <= r_cnt + 64'd1;
            end
        end
    end

    assign cnt      = r_cnt;
    assign cnt_tick = r_tick;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops one entry per clock edge and compares.
module tb_cnt_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        halt_req;
    logic        halt_ack;
    logic        tdr0_wr_sel;
    logic        tdr1_wr_sel;
    logic [31:0] wdata;
    logic [3:0]  pstrb;
    logic [63:0] cnt;
    logic        cnt_tick;

    typedef struct {
        string       name;
        logic [63:0] cnt;
        logic        tick;
        logic        ack;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    cnt_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .timer_en    (timer_en),
        .div_en      (div_en),
        .div_val     (div_val),
        .halt_req    (halt_req),
        .halt_ack    (halt_ack),
        .tdr0_wr_sel (tdr0_wr_sel),
        .tdr1_wr_sel (tdr1_wr_sel),
        .wdata       (wdata),
        .pstrb       (pstrb),
        .cnt         (cnt),
        .cnt_tick    (cnt_tick)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: one expectation per checked edge, sampled 1 time unit after it
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_total++;
                if (cnt === e.cnt) n_pass++;
                else $display("FAIL %s cnt: got %h want %h", e.name, cnt, e.cnt);
                n_total++;
                if (cnt_tick === e.tick) n_pass++;
                else $display("FAIL %s cnt_tick: got %b want %b", e.name, cnt_tick, e.tick);
                n_total++;
                if (halt_ack === e.ack) n_pass++;
                else $display("FAIL %s halt_ack: got %b want %b", e.name, halt_ack, e.ack);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    // Clock one edge with the current inputs and queue what must follow it
    task automatic step(input string nm, input logic [63:0] c, input logic t, input logic a);
        exp_t e;
        @(posedge sys_clk);
        e.name = nm;
        e.cnt  = c;
        e.tick = t;
        e.ack  = a;
        q.push_back(e);
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
        halt_req = 1'b0; tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0;
        wdata = 32'd0; pstrb = 4'd0;

        // Reset state, and reset beating a write
        step("reset", 64'd0, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'hFFFF_FFFF;
        step("reset_over_wr", 64'd0, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b0;

        // Undivided run for 10 edges: first edge enters RUN, then 9 increments
        sys_rst = 1'b0; timer_en = 1'b1;
        for (int i = 1; i <= 10; i++)
            step($sformatf("div0_run%0d", i), 64'(i - 1), (i > 1), 1'b0);
        timer_en = 1'b0;
        step("div0_stop", 64'd9, 1'b0, 1'b0);
        step("div0_idle", 64'd9, 1'b0, 1'b0);

        // Prescale exponent 2: one increment per 4 edges
        div_en = 1'b1; div_val = 4'd2;
        step("div2_cfg", 64'd9, 1'b0, 1'b0);
        timer_en = 1'b1;
        step("div2_enter", 64'd9, 1'b0, 1'b0);
        for (int j = 1; j <= 16; j++)
            step($sformatf("div2_run%0d", j), 64'(9 + j / 4), (j % 4 == 0), 1'b0);
        timer_en = 1'b0;
        step("div2_stop", 64'd13, 1'b0, 1'b0);

        // Exponent 12 saturates to 8: period 256
        div_val = 4'd12;
        step("div12_cfg", 64'd13, 1'b0, 1'b0);
        timer_en = 1'b1;
        step("div12_enter", 64'd13, 1'b0, 1'b0);
        for (int j = 1; j <= 256; j++)
            step($sformatf("div12_run%0d", j), (j == 256) ? 64'd14 : 64'd13, (j == 256), 1'b0);
        timer_en = 1'b0;
        step("div12_stop", 64'd14, 1'b0, 1'b0);

        // Word writes then wrap through all-ones
        div_en = 1'b0; tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'hFFFF_FFFE;
        step("wr_lo", 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b1; wdata = 32'hFFFF_FFFF;
        step("wr_hi", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        tdr1_wr_sel = 1'b0; timer_en = 1'b1;
        step("wrap_enter", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        step("wrap_ffff", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        step("wrap_zero", 64'h0000_0000_0000_0000, 1'b1, 1'b0);
        step("wrap_one", 64'h0000_0000_0000_0001, 1'b1, 1'b0);
        timer_en = 1'b0;
        step("wrap_stop", 64'd1, 1'b0, 1'b0);

        // Both words at once, then byte-masked writes colliding with increments
        tdr0_wr_sel = 1'b1; tdr1_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'h0000_0010;
        step("wr_both", 64'h0000_0010_0000_0010, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; timer_en = 1'b1;
        step("strb_enter", 64'h0000_0010_0000_0010, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b1; pstrb = 4'b0010; wdata = 32'h0000_AB00;
        step("strb_lo_b1", 64'h0000_0010_0000_AB10, 1'b0, 1'b0);
        tdr0_wr_sel = 1'b0;
        step("strb_inc1", 64'h0000_0010_0000_AB11, 1'b1, 1'b0);
        tdr1_wr_sel = 1'b1; pstrb = 4'b1000; wdata = 32'hAA00_0000;
        step("strb_hi_b3", 64'hAA00_0010_0000_AB11, 1'b0, 1'b0);
        tdr1_wr_sel = 1'b0;
        step("strb_inc2", 64'hAA00_0010_0000_AB12, 1'b1, 1'b0);

        // Halt request during RUN
        halt_req = 1'b1;
`ifdef CNT_HALT_EN
        step("halt_enter", 64'hAA00_0010_0000_AB12, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++)
            step($sformatf("halt_hold%0d", k), 64'hAA00_0010_0000_AB12, 1'b0, 1'b1);
        halt_req = 1'b0;
        step("halt_exit", 64'hAA00_0010_0000_AB12, 1'b0, 1'b0);
`endif
        for (int k = 3; k <= 5; k++)
            step($sformatf("halt_run%0d", k), 64'hAA00_0010_0000_AB10 + 64'(k), 1'b1, 1'b0);
        halt_req = 1'b0;

        // Reset in the middle of counting, with a write pending
        sys_rst = 1'b1; tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'hFFFF_FFFF;
        step("midrst", 64'd0, 1'b0, 1'b0);
        sys_rst = 1'b0; tdr0_wr_sel = 1'b0;
        step("midrst_enter", 64'd0, 1'b0, 1'b0);
        step("midrst_inc", 64'd1, 1'b1, 1'b0);

        // Reconfiguring the prescaler restarts it
        div_en = 1'b1; div_val = 4'd2;
        step("chg_en", 64'd1, 1'b0, 1'b0);
        step("chg_p1", 64'd1, 1'b0, 1'b0);
        step("chg_p2", 64'd1, 1'b0, 1'b0);
        div_val = 4'd1;
        step("chg_val", 64'd1, 1'b0, 1'b0);
        step("chg_v1a", 64'd1, 1'b0, 1'b0);
        step("chg_v1b", 64'd2, 1'b1, 1'b0);
        step("chg_v1c", 64'd2, 1'b0, 1'b0);
        step("chg_v1d", 64'd3, 1'b1, 1'b0);

        // Exponent 9 behaves as 8
        div_val = 4'd9;
        step("div9_cfg", 64'd3, 1'b0, 1'b0);
        for (int j = 1; j <= 256; j++)
            step($sformatf("div9_run%0d", j), (j == 256) ? 64'd4 : 64'd3, (j == 256), 1'b0);

        #2;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
